// File: rtl/fetch_prefetch_pkg.sv
// Shared constants for the instruction-fetch front end.
//   FP_ADDR_W / FP_INST_W : default address and instruction widths
//   FP_RESET_PC           : first fetch address after reset
//   WORD_STEP             : byte distance between consecutive instruction words
//   NOP_INST              : canonical NOP (addi x0,x0,0), used by IF/ID for bubbles
package fetch_prefetch_pkg;

  localparam int               FP_ADDR_W   = 32;
  localparam int               FP_INST_W   = 32;
  localparam logic [31:0]      FP_RESET_PC = 32'h0000_0000;
  localparam int               WORD_STEP   = 4;
  localparam logic [31:0]      NOP_INST    = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, inst} entries between instruction memory and IF/ID.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : drop the head entry (caller guarantees count != 0)
//   flush      : empty the FIFO; wins over push and pop in the same cycle
//   count      : current occupancy, 0..DEPTH
//   head       : entry at the head (undefined when count == 0)
module fetch_fifo
  import fetch_prefetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FP_ADDR_W + FP_INST_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop  && !flush;

  // NOTE: storage is deliberately not reset; validity is tracked by count_q,
  // so clearing the array would only cost reset fan-out for no benefit.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  a_no_push_full : assert property (@(posedge clk) disable iff (rst)
    !(do_push && count_q == CW'(DEPTH)));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (rst)
    !(do_pop && count_q == '0));

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction-fetch front end feeding the IF/ID register.
//   clk, rst        : clock, asynchronous active-high reset
//   br, br_addr     : taken-branch redirect from ID and its target
//   out_ready       : IF/ID can accept the head entry
//   out_valid/pc/inst : head entry of the prefetch FIFO (zero when empty)
//   stallreq_if     : asserted while no instruction is available
//   mem_req/addr    : word fetch request, held until mem_gnt
//   mem_gnt         : request accepted this cycle
//   mem_rvalid/rdata: in-order response from instruction memory
// Requests are credit limited so FIFO occupancy plus outstanding requests never
// exceeds DEPTH; every response therefore has a free FIFO slot waiting for it.
module fetch_prefetch
  import fetch_prefetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = FP_ADDR_W,
  parameter int                INST_W   = FP_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FP_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br,
  input  logic [ADDR_W-1:0] br_addr,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              stallreq_if,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(WORD_STEP);

  logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]        resp_pc_q, resp_pc_d;
  logic [CW-1:0]            inflight_q, inflight_d;
  logic [CW-1:0]            discard_q, discard_d;
  logic [CW-1:0]            fifo_count;
  logic [ADDR_W+INST_W-1:0] fifo_head;
  logic [ADDR_W-1:0]        br_target;
  logic                     issue, live_resp, pop;

  assign br_target = br_addr & ALIGN_MASK;
  assign mem_addr  = fetch_pc_q & ALIGN_MASK;

  // Credit check; mem_req is forced low during reset so nothing leaks out.
  assign mem_req   = !rst && !br && ((SW'(fifo_count) + SW'(inflight_q)) < SW'(DEPTH));
  assign issue     = mem_req && mem_gnt;

  // Responses are dropped while stale requests remain, and always in a br cycle.
  assign live_resp = mem_rvalid && !br && (discard_q == '0);
  assign pop       = out_valid && out_ready && !br;

  assign inflight_d = inflight_q + CW'(issue) - CW'(mem_rvalid);

  // NOTE: every variable gets its default first so no path leaves it unassigned
  // (which would infer a latch); combinational blocks use blocking '='.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    if (br) begin
      fetch_pc_d = br_target;
      resp_pc_d  = br_target;
      // Everything still outstanding after this cycle belongs to the old path.
      discard_d  = inflight_d;
    end else begin
      if (issue)     fetch_pc_d = fetch_pc_q + STEP;
      if (live_resp) resp_pc_d  = resp_pc_q + STEP;
      if (mem_rvalid && discard_q != '0) discard_d = discard_q - 1'b1;
    end
  end

  // NOTE: clocked state uses non-blocking '<=' so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + INST_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (live_resp),
    .push_data ({resp_pc_q, mem_rdata}),
    .pop       (pop),
    .flush     (br),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Outputs are gated to zero when empty so unreset storage never shows.
  assign out_valid   = (fifo_count != '0);
  assign out_pc      = out_valid ? fifo_head[ADDR_W+INST_W-1:INST_W] : '0;
  assign out_inst    = out_valid ? fifo_head[INST_W-1:0] : '0;
  assign stallreq_if = !out_valid;

  a_resp_expected : assert property (@(posedge clk) disable iff (rst)
    !(mem_rvalid && inflight_q == '0));

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: a fixed-latency in-order memory responder,
// a table of per-cycle vectors with hand-computed outputs, and a hand-written
// asynchronous-reset sequence. Response data is always addr ^ 32'hA5A5_0000.
module tb_fetch_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        br = 1'b0;
  logic [31:0] br_addr = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        stallreq_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  fetch_prefetch #(
    .DEPTH    (4),
    .ADDR_W   (32),
    .INST_W   (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .br          (br),
    .br_addr     (br_addr),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .stallreq_if (stallreq_if),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t rq[$];
  int   cyc = 0;
  int   lat = 1;

  // One clock: note any grant just before the edge, then update the responder.
  // A grant seen at edge e is answered with rvalid sampled at edge e+lat.
  task automatic run_cycle();
    logic        g;
    logic [31:0] a;
    g = mem_req && mem_gnt;
    a = mem_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      rq.delete();
    end else begin
      if (mem_rvalid && rq.size() > 0) void'(rq.pop_front());
      if (g) rq.push_back('{a, cyc + lat});
    end
    mem_rvalid = (rq.size() > 0) && (rq[0].due == cyc + 1);
    mem_rdata  = mem_rvalid ? (rq[0].addr ^ DATA_KEY) : 32'h0;
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1;
    br = 1'b0; br_addr = '0; out_ready = 1'b0; mem_gnt = 1'b0;
    lat = l;
    rq.delete();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    repeat (2) @(posedge clk);
    #2;
    check("reset out_valid",   {31'b0, out_valid},   32'h0);
    check("reset stallreq_if", {31'b0, stallreq_if}, 32'h1);
    check("reset mem_req",     {31'b0, mem_req},     32'h0);
    check("reset out_pc",      out_pc,               32'h0);
    check("reset out_inst",    out_inst,             32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          tst;
    int          lat;
    bit          br;
    logic [31:0] br_addr;
    bit          rdy;
    bit          gnt;
    bit          ev;
    logic [31:0] epc;
    bit          ereq;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int tst, input int l, input bit b, input logic [31:0] ba,
                     input bit rdy, input bit gnt, input bit ev, input logic [31:0] epc,
                     input bit ereq, input logic [31:0] eaddr);
    vecs.push_back('{tst, l, b, ba, rdy, gnt, ev, epc, ereq, eaddr});
  endtask

  initial begin
    vec_t v;
    int   row;
    string tag;

    //   tst lat br br_addr rdy gnt | ev  pc       req addr
    // 1: sequential fetch, 1-cycle memory
    add(1, 1, 0, 0, 1, 1,  0, 32'h0,   1, 32'h00);
    add(1, 1, 0, 0, 1, 1,  0, 32'h0,   1, 32'h04);
    add(1, 1, 0, 0, 1, 1,  1, 32'h0,   1, 32'h08);
    add(1, 1, 0, 0, 1, 1,  1, 32'h4,   1, 32'h0C);
    add(1, 1, 0, 0, 1, 1,  1, 32'h8,   1, 32'h10);
    add(1, 1, 0, 0, 1, 1,  1, 32'hC,   1, 32'h14);
    // 2: backpressure fills FIFO, credit stops requests, then drains in order
    add(2, 1, 0, 0, 0, 1,  0, 32'h0,   1, 32'h00);
    add(2, 1, 0, 0, 0, 1,  0, 32'h0,   1, 32'h04);
    add(2, 1, 0, 0, 0, 1,  1, 32'h0,   1, 32'h08);
    add(2, 1, 0, 0, 0, 1,  1, 32'h0,   1, 32'h0C);
    for (int k = 0; k < 6; k++)
      add(2, 1, 0, 0, 0, 1, 1, 32'h0,  0, 32'h10);
    add(2, 1, 0, 0, 1, 1,  1, 32'h0,   0, 32'h10);
    add(2, 1, 0, 0, 1, 1,  1, 32'h4,   1, 32'h10);
    add(2, 1, 0, 0, 1, 1,  1, 32'h8,   1, 32'h14);
    add(2, 1, 0, 0, 1, 1,  1, 32'hC,   1, 32'h18);
    add(2, 1, 0, 0, 1, 1,  1, 32'h10,  1, 32'h1C);
    // 3: redirect to 0x100 with requests for 8 and 12 outstanding (3-cycle memory)
    add(3, 3, 0, 0, 1, 1,  0, 32'h0,   1, 32'h00);
    add(3, 3, 0, 0, 1, 1,  0, 32'h0,   1, 32'h04);
    add(3, 3, 0, 0, 1, 0,  0, 32'h0,   1, 32'h08);
    add(3, 3, 0, 0, 1, 0,  0, 32'h0,   1, 32'h08);
    add(3, 3, 0, 0, 1, 1,  1, 32'h0,   1, 32'h08);
    add(3, 3, 0, 0, 1, 1,  1, 32'h4,   1, 32'h0C);
    add(3, 3, 1, 32'h100, 1, 0, 0, 32'h0, 0, 32'h10);
    add(3, 3, 0, 0, 1, 1,  0, 32'h0,   1, 32'h100);
    add(3, 3, 0, 0, 1, 1,  0, 32'h0,   1, 32'h104);
    add(3, 3, 0, 0, 1, 1,  0, 32'h0,   1, 32'h108);
    add(3, 3, 0, 0, 1, 1,  0, 32'h0,   1, 32'h10C);
    add(3, 3, 0, 0, 1, 1,  1, 32'h100, 0, 32'h110);
    add(3, 3, 0, 0, 1, 1,  1, 32'h104, 1, 32'h110);
    // 4: misaligned redirect in a cycle that also carries a response
    add(4, 1, 0, 0, 1, 1,  0, 32'h0,   1, 32'h00);
    add(4, 1, 0, 0, 1, 1,  0, 32'h0,   1, 32'h04);
    add(4, 1, 0, 0, 1, 1,  1, 32'h0,   1, 32'h08);
    add(4, 1, 1, 32'h102, 1, 1, 1, 32'h4, 0, 32'h0C);
    add(4, 1, 0, 0, 1, 1,  0, 32'h0,   1, 32'h100);
    add(4, 1, 0, 0, 1, 1,  0, 32'h0,   1, 32'h104);
    add(4, 1, 0, 0, 1, 1,  1, 32'h100, 1, 32'h108);
    add(4, 1, 0, 0, 1, 1,  1, 32'h104, 1, 32'h10C);
    // 5: grant withheld for 3 cycles holds mem_addr at 0x10
    add(5, 1, 0, 0, 1, 1,  0, 32'h0,   1, 32'h00);
    add(5, 1, 0, 0, 1, 1,  0, 32'h0,   1, 32'h04);
    add(5, 1, 0, 0, 1, 1,  1, 32'h0,   1, 32'h08);
    add(5, 1, 0, 0, 1, 1,  1, 32'h4,   1, 32'h0C);
    add(5, 1, 0, 0, 1, 0,  1, 32'h8,   1, 32'h10);
    add(5, 1, 0, 0, 1, 0,  1, 32'hC,   1, 32'h10);
    add(5, 1, 0, 0, 1, 0,  0, 32'h0,   1, 32'h10);
    add(5, 1, 0, 0, 1, 1,  0, 32'h0,   1, 32'h10);
    add(5, 1, 0, 0, 1, 1,  0, 32'h0,   1, 32'h14);
    add(5, 1, 0, 0, 1, 1,  1, 32'h10,  1, 32'h18);

    row = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (i == 0 || v.tst != vecs[i-1].tst) begin
        do_reset(v.lat);
        row = 0;
      end
      br = v.br; br_addr = v.br_addr; out_ready = v.rdy; mem_gnt = v.gnt;
      #1;
      tag = $sformatf("t%0d.c%0d", v.tst, row);
      check({tag, " out_valid"},   {31'b0, out_valid},   {31'b0, v.ev});
      check({tag, " stallreq_if"}, {31'b0, stallreq_if}, {31'b0, !v.ev});
      check({tag, " out_pc"},      out_pc,   v.ev ? v.epc : 32'h0);
      check({tag, " out_inst"},    out_inst, v.ev ? (v.epc ^ DATA_KEY) : 32'h0);
      check({tag, " mem_req"},     {31'b0, mem_req},     {31'b0, v.ereq});
      check({tag, " mem_addr"},    mem_addr, v.eaddr);
      run_cycle();
      row++;
    end

    // 6: asynchronous reset between edges with three entries buffered
    do_reset(1);
    out_ready = 1'b0;
    mem_gnt   = 1'b1;
    repeat (4) run_cycle();
    #1;
    check("t6 pre-reset out_valid", {31'b0, out_valid}, 32'h1);
    check("t6 pre-reset out_pc",    out_pc,             32'h0);
    #1;
    rst = 1'b1;
    #1;
    check("t6 async out_valid",   {31'b0, out_valid},   32'h0);
    check("t6 async mem_req",     {31'b0, mem_req},     32'h0);
    check("t6 async stallreq_if", {31'b0, stallreq_if}, 32'h1);
    check("t6 async out_pc",      out_pc,               32'h0);
    run_cycle();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    out_ready = 1'b1;
    #1;
    check("t6 release mem_req",   {31'b0, mem_req},   32'h1);
    check("t6 release mem_addr",  mem_addr,           32'h0);
    check("t6 release out_valid", {31'b0, out_valid}, 32'h0);
    repeat (2) run_cycle();
    #1;
    check("t6 refetch out_valid", {31'b0, out_valid}, 32'h1);
    check("t6 refetch out_pc",    out_pc,             32'h0);
    check("t6 refetch out_inst",  out_inst,           DATA_KEY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
